// File: rtl/keypad_scan_debouncer.sv
// 4x4 matrix keypad column scanner with press/release debounce and one-hot key report.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_strobe every REPEAT_TICKS ticks while a key is held.
module keypad_scan_debouncer #(
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_TICKS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] keypad_row_in,
  output logic [3:0] keypad_col_out,
  output logic [3:0] row_out,
  output logic [3:0] col_out,
  output logic       key_pressed,
  output logic       key_strobe
);

  localparam int unsigned     PRE_W    = $clog2(CLK_DIV);
  localparam int unsigned     DEB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    S_SCAN      = 2'd0,
    S_PRESS_DEB = 2'd1,
    S_HELD      = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_s;
  logic [PRE_W-1:0] r_presc;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_cap_row;
  logic [DEB_W-1:0] r_deb_cnt;

  logic       w_tick;
  logic [3:0] w_row_low;
  logic       w_all_high;
  logic       w_one_low;
  logic [1:0] w_col_inc;
  logic [3:0] w_drv_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned     REP_W    = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
  logic [REP_W-1:0] r_rep_cnt;
`else
  // REPEAT_TICKS has no effect in this build.
  if (REPEAT_TICKS == 0) begin : g_repeat_unused
  end
`endif

  assign w_tick     = (r_presc == PRE_LAST);
  assign w_row_low  = ~r_row_s;
  assign w_all_high = (r_row_s == 4'hF);
  assign w_one_low  = (w_row_low != 4'h0) && ((w_row_low & (w_row_low - 4'd1)) == 4'h0);
  assign w_col_inc  = r_col_idx + 2'd1;
  assign w_drv_inc  = ~(4'b0001 << w_col_inc);

  // Two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_meta <= 4'hF;
      r_row_s    <= 4'hF;
    end else begin
      r_row_meta <= keypad_row_in;
      r_row_s    <= r_row_meta;
    end
  end

  // Scan tick prescaler.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
    end
  end

  // Scan / debounce FSM; the column stays frozen outside SCAN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_SCAN;
      r_col_idx      <= 2'd0;
      r_cap_row      <= 4'h0;
      r_deb_cnt      <= '0;
      keypad_col_out <= 4'b1110;
      row_out        <= 4'h0;
      col_out        <= 4'h0;
      key_pressed    <= 1'b0;
      key_strobe     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep_cnt      <= '0;
`endif
    end else begin
      key_strobe <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_one_low) begin
              r_cap_row <= w_row_low;
              r_deb_cnt <= DEB_W'(1);
              r_state   <= S_PRESS_DEB;
            end else begin
              r_col_idx      <= w_col_inc;
              keypad_col_out <= w_drv_inc;
            end
          end
          S_PRESS_DEB: begin
            if (w_row_low != r_cap_row) begin
              r_state <= S_SCAN;
            end else if (r_deb_cnt == DEB_LAST) begin
              r_state     <= S_HELD;
              r_deb_cnt   <= '0;
              row_out     <= r_cap_row;
              col_out     <= 4'b0001 << r_col_idx;
              key_pressed <= 1'b1;
              key_strobe  <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              r_rep_cnt   <= '0;
`endif
            end else begin
              r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
          end
          S_HELD: begin
            if (w_all_high) begin
`ifdef KEYPAD_AUTOREPEAT_EN
              r_rep_cnt <= '0;
`endif
              if (r_deb_cnt == DEB_LAST) begin
                r_state        <= S_SCAN;
                r_deb_cnt      <= '0;
                row_out        <= 4'h0;
                col_out        <= 4'h0;
                key_pressed    <= 1'b0;
                r_col_idx      <= w_col_inc;
                keypad_col_out <= w_drv_inc;
              end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
              end
            end else begin
              r_deb_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              if (r_rep_cnt == REP_LAST) begin
                key_strobe <= 1'b1;
                r_rep_cnt  <= '0;
              end else begin
                r_rep_cnt <= r_rep_cnt + REP_W'(1);
              end
`endif
            end
          end
          default: r_state <= S_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debouncer.sv
// Self-checking bench for keypad_scan_debouncer: a physical keypad matrix drives the rows,
// a tick-level behavioural reference predicts every output cycle by cycle.
module tb_keypad_scan_debouncer;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;
  localparam int REP     = 5;
  localparam logic [13:0] IDLE_VEC = 14'b1110_0000_0000_00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  keypad_row_in;
  logic [3:0]  keypad_col_out;
  logic [3:0]  row_out;
  logic [3:0]  col_out;
  logic        key_pressed;
  logic        key_strobe;
  logic [15:0] keys;
  int          n_checks;
  int          n_fail;

  keypad_scan_debouncer #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_TICKS(DEB),
    .REPEAT_TICKS(REP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .keypad_row_in(keypad_row_in),
    .keypad_col_out(keypad_col_out),
    .row_out(row_out),
    .col_out(col_out),
    .key_pressed(key_pressed),
    .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key (row r, col c) pulls row r low while column c is driven low.
  always_comb begin
    keypad_row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !keypad_col_out[c]) keypad_row_in[r] = 1'b0;
  end

  // Reference: mode 0 = looking, 1 = confirming a candidate, 2 = key held.
  logic [3:0] p1, p2, m_cand, e_row, e_col, m_down, e_drv;
  logic [1:0] m_col;
  logic       e_pressed, e_strobe;
  int         m_pre, m_mode, m_run;
`ifdef KEYPAD_AUTOREPEAT_EN
  int         m_rep;
`endif
  logic [13:0] dut_vec, ref_vec;

  assign m_down  = ~p2;
  assign e_drv   = ~(4'b0001 << m_col);
  assign dut_vec = {keypad_col_out, row_out, col_out, key_pressed, key_strobe};
  assign ref_vec = {e_drv, e_row, e_col, e_pressed, e_strobe};

  always @(posedge clk) begin
    if (!rst_n) begin
      p1 <= 4'hF; p2 <= 4'hF; m_pre <= 0; m_col <= 2'd0; m_mode <= 0; m_run <= 0;
      m_cand <= 4'h0; e_row <= 4'h0; e_col <= 4'h0; e_pressed <= 1'b0; e_strobe <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      m_rep <= 0;
`endif
    end else begin
      p1 <= keypad_row_in;
      p2 <= p1;
      e_strobe <= 1'b0;
      m_pre <= (m_pre == CLK_DIV - 1) ? 0 : m_pre + 1;
      if (m_pre == CLK_DIV - 1) begin
        if (m_mode == 0) begin
          if ($countones(m_down) == 1) begin
            m_mode <= 1; m_cand <= m_down; m_run <= 1;
          end else begin
            m_col <= m_col + 2'd1;
          end
        end else if (m_mode == 1) begin
          if (m_down != m_cand) m_mode <= 0;
          else if (m_run + 1 == DEB) begin
            m_mode <= 2; m_run <= 0; e_pressed <= 1'b1; e_row <= m_cand;
            e_col <= 4'b0001 << m_col; e_strobe <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            m_rep <= 0;
`endif
          end else m_run <= m_run + 1;
        end else begin
          if (m_down == 4'h0) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            m_rep <= 0;
`endif
            if (m_run + 1 == DEB) begin
              m_mode <= 0; m_run <= 0; e_pressed <= 1'b0; e_row <= 4'h0; e_col <= 4'h0;
              m_col <= m_col + 2'd1;
            end else m_run <= m_run + 1;
          end else begin
            m_run <= 0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (m_rep + 1 == REP) begin
              e_strobe <= 1'b1; m_rep <= 0;
            end else m_rep <= m_rep + 1;
`endif
          end
        end
      end
    end
  end

  task automatic test_reset();
    logic [3:0] want;
    keys = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_vec !== IDLE_VEC) begin
      n_fail++; $display("FAIL reset_state got=%h want=%h", dut_vec, IDLE_VEC);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      want = ~(4'b0001 << (((k + 1) / CLK_DIV) % 4));
      n_checks++;
      if (keypad_col_out !== want) begin
        n_fail++; $display("FAIL idle_col_drive cyc=%0d got=%b want=%b", k, keypad_col_out, want);
      end
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL idle_model cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
    end
  endtask

  task automatic test_press();
    int strobes = 0;
    keys = 16'h0200;  // row 2, column 1
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL press_model cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
      if (key_strobe === 1'b1) strobes++;
    end
    n_checks++;
    if ({row_out, col_out, key_pressed} !== {4'b0100, 4'b0010, 1'b1}) begin
      n_fail++; $display("FAIL press_outputs got=%b_%b_%b want=0100_0010_1", row_out, col_out, key_pressed);
    end
    n_checks++;
    if (strobes != 1) begin
      n_fail++; $display("FAIL press_strobe_count got=%0d want=1", strobes);
    end
  endtask

  task automatic test_release();
    logic prev = e_pressed;
    bit   fell = 0;
    keys = 16'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL release_model cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
      if (prev && !e_pressed) begin
        fell = 1;
        n_checks++;
        if (keypad_col_out !== 4'b1011) begin
          n_fail++; $display("FAIL release_resume_col got=%b want=1011", keypad_col_out);
        end
      end
      prev = e_pressed;
    end
    n_checks++;
    if (!fell || {row_out, col_out, key_pressed} !== 9'h0) begin
      n_fail++; $display("FAIL release_cleared fell=%0d got=%b_%b_%b want=0", fell, row_out, col_out, key_pressed);
    end
  endtask

  task automatic test_bounce();
    int  strobes = 0;
    bit  ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (m_pre == 0 && m_col == 2'd3) ok = 1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bounce_align timeout got=0 want=1"); end
    keys = 16'h0080;  // row 1, column 3
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL bounce_model cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
      if (key_strobe === 1'b1) strobes++;
      if (k == 19) begin
        n_checks++;
        if (strobes != 0) begin n_fail++; $display("FAIL bounce_early_strobe got=%0d want=0", strobes); end
      end
      if (k == 4) keys = 16'h0;
      if (k == 8) keys = 16'h0080;
    end
    n_checks++;
    if (strobes != 1 || key_pressed !== 1'b1) begin
      n_fail++; $display("FAIL bounce_single_press strobes=%0d pressed=%b want=1,1", strobes, key_pressed);
    end
    keys = 16'h0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL bounce_release cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
    end
  endtask

  task automatic test_multikey();
    int   strobes = 0;
    int   changes = 0;
    bit   ok = 0;
    logic [3:0] prev;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (m_pre == 0 && m_col == 2'd0) ok = 1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ghost_align timeout got=0 want=1"); end
    keys = 16'h0011;  // rows 0 and 1 on column 0
    prev = keypad_col_out;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL ghost_model cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
      if (key_strobe === 1'b1) strobes++;
      if (keypad_col_out !== prev) changes++;
      prev = keypad_col_out;
    end
    n_checks++;
    if (strobes != 0 || key_pressed !== 1'b0 || changes != 10) begin
      n_fail++; $display("FAIL ghost_ignored strobes=%0d pressed=%b col_steps=%0d want=0,0,10", strobes, key_pressed, changes);
    end
    keys = 16'h0;
  endtask

  task automatic test_glitch();
    bit ok = 0;
    int drops = 0;
    keys = 16'h4000;  // row 3, column 2
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL glitch_press cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
      if (e_pressed) ok = 1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL glitch_confirm timeout got=0 want=1"); end
    keys = 16'h0;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (k == 3) keys = 16'h4000;
      if (key_pressed !== 1'b1) drops++;
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL glitch_model cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
    end
    n_checks++;
    if (drops != 0) begin n_fail++; $display("FAIL glitch_hold drops=%0d want=0", drops); end
    keys = 16'h0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL glitch_release cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
    end
  endtask

  task automatic test_repeat();
    bit ok = 0;
    int reps = 0;
    int last = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
    int want_reps = 4;
`else
    int want_reps = 0;
`endif
    keys = 16'h0008;  // row 0, column 3
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL repeat_press cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
      if (e_pressed) ok = 1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL repeat_confirm timeout got=0 want=1"); end
    for (int k = 1; k <= 82; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL repeat_model cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
      if (key_strobe === 1'b1) begin
        reps++;
        n_checks++;
        if (k - last != REP * CLK_DIV) begin
          n_fail++; $display("FAIL repeat_spacing got=%0d want=%0d", k - last, REP * CLK_DIV);
        end
        last = k;
      end
    end
    n_checks++;
    if (reps != want_reps) begin n_fail++; $display("FAIL repeat_count got=%0d want=%0d", reps, want_reps); end
    keys = 16'h0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL repeat_release cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int r = int'($urandom_range(0, 3));
      int c = int'($urandom_range(0, 3));
      int hold = int'($urandom_range(30, 90));
      int gap = int'($urandom_range(24, 48));
      bit bounce = 1'($urandom_range(0, 1));
      bit ghost = ($urandom_range(0, 3) == 0);
      int s_dut = 0;
      int s_ref = 0;
      logic [15:0] base = 16'h0001 << (r * 4 + c);
      logic [15:0] other = 16'h0001 << (((r + 1) % 4) * 4 + c);
      for (int k = 0; k < hold + gap; k++) begin
        @(negedge clk);
        n_checks++;
        if (dut_vec !== ref_vec) begin
          n_fail++; $display("FAIL random_model it=%0d cyc=%0d got=%h want=%h", it, k, dut_vec, ref_vec);
        end
        if (key_strobe === 1'b1) s_dut++;
        if (e_strobe) s_ref++;
        if (k >= hold) keys = 16'h0;
        else if (bounce && k < 6) keys = ($urandom_range(0, 1) != 0) ? base : 16'h0;
        else if (ghost && k >= hold / 2 && k < hold / 2 + 8) keys = base | other;
        else keys = base;
      end
      n_checks++;
      if (s_dut != s_ref) begin
        n_fail++; $display("FAIL random_strobes it=%0d got=%0d want=%0d", it, s_dut, s_ref);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    bit ok = 0;
    keys = 16'h0010;  // row 1, column 0
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      if (e_pressed) ok = 1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midhold_confirm timeout got=0 want=1"); end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== IDLE_VEC) begin
      n_fail++; $display("FAIL midhold_reset got=%h want=%h", dut_vec, IDLE_VEC);
    end
    rst_n = 1'b1;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (m_mode == 1) ok = 1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL middeb_candidate timeout got=0 want=1"); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== IDLE_VEC) begin
      n_fail++; $display("FAIL middeb_reset got=%h want=%h", dut_vec, IDLE_VEC);
    end
    keys = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== ref_vec) begin
        n_fail++; $display("FAIL post_reset_model cyc=%0d got=%h want=%h", k, dut_vec, ref_vec);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    keys     = 16'h0;
    rst_n    = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_multikey();
    test_glitch();
    test_repeat();
    test_random();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debouncer.md
# keypad_scan_debouncer

Scans the 4×4 matrix keypad and debounces key presses. Drives one column low at a time, samples the active-low rows and confirms a key only after a stable run of samples. Publishes the confirmed key's one-hot row/column to `keypad_encoder` and a level `key_pressed` to the calculator FSM, which edge-detects it. Sits between the keypad pins (`IO_P4_ROW`/`IO_P4_COL`) and `keypad_encoder`.

## Interface
- `CLK_DIV`, default 50000: clock cycles per scan tick; legal range ≥ 2.
- `DEBOUNCE_TICKS`, default 4: consecutive identical samples that confirm a press or a release; legal range ≥ 2.
- `REPEAT_TICKS`, default 250: auto-repeat period in ticks; used only with `KEYPAD_AUTOREPEAT_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low. All state updates on the `clk` rising edge.
- `keypad_row_in`  in  4  raw rows, active-low, externally pulled up, asynchronous.
- `keypad_col_out`  out  4  column drive, active-low one-hot.
- `row_out`  out  4  confirmed key row, active-high one-hot; 0 when no key is held.
- `col_out`  out  4  confirmed key column, active-high one-hot; 0 when no key is held.
- `key_pressed`  out  1  high while a debounced key is held.
- `key_strobe`  out  1  one-cycle pulse per accepted key event.

## Operation
- Input sync: `keypad_row_in` passes through 2 flops to give `row_s`. All decisions use `row_s`.
- Prescaler: counts 0..`CLK_DIV`-1 and wraps. `tick` = (count == `CLK_DIV`-1). States change only on tick cycles.
- `col_idx` (2 bits) selects the driven column: `keypad_col_out` = ~(1 << `col_idx`).
- SCAN, on each tick:
  - `row_s` all high: `col_idx` += 1 (wrapping 3→0); stay in SCAN.
  - Exactly one `row_s` bit low: `cap_row` = ~`row_s`, `deb_cnt` = 1, go to PRESS_DEB. `col_idx` is frozen from here until the block returns to SCAN.
  - More than one bit low (ghost/multi-key): treat as no key and advance the column.
- PRESS_DEB, on each tick:
  - ~`row_s` == `cap_row`: `deb_cnt` += 1.
  - Otherwise: go to SCAN. `col_idx` is not advanced, so this column is re-sampled.
  - When `deb_cnt` reaches `DEBOUNCE_TICKS`: go to HELD and, in the same update, set `row_out` = `cap_row`, `col_out` = 1 << `col_idx`, `key_pressed` = 1, `key_strobe` = 1.
- HELD, on each tick:
  - `row_s` all high: `deb_cnt` += 1.
  - Any row low: `deb_cnt` = 0. Presses in other columns cannot be seen because the column stays frozen.
  - On entry to HELD `deb_cnt` is reset to 0.
  - When `deb_cnt` reaches `DEBOUNCE_TICKS`: go to SCAN, clear `row_out`, `col_out` and `key_pressed`, and advance `col_idx`.
- `key_strobe` is high for exactly one cycle. It is cleared on every cycle it is not being set.
- Reset values: state = SCAN, `col_idx` = 0, prescaler = 0, `deb_cnt` = 0, sync flops = 4'hF, `keypad_col_out` = 4'b1110, `row_out` = 0, `col_out` = 0, `key_pressed` = 0, `key_strobe` = 0. Reset asserted mid-debounce or mid-hold drops `key_pressed` on the next edge; it produces no strobe.
- Counter widths are sized with `$clog2` of the parameter; counters never wrap.

## Timing
- Input latency: 2 cycles from pin to `row_s`.
- Column settle time: `CLK_DIV` cycles between a column change and its first sample.
- Press latency: the press is detected on tick T0. `key_pressed`, `row_out`, `col_out` and `key_strobe` become visible one cycle after tick T0+`DEBOUNCE_TICKS`-1.
- Release latency: `DEBOUNCE_TICKS` consecutive released ticks. Outputs clear one cycle after the last of those ticks.
- `row_out` and `col_out` change only when `key_pressed` changes. They are stable while `key_pressed` = 1.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In HELD, a repeat counter counts ticks while the key stays down. It resets on entry to HELD and on each repeat.
  - Every `REPEAT_TICKS` ticks it re-pulses `key_strobe`.
  - `key_pressed`, `row_out` and `col_out` are unchanged.
  - A release sample resets the repeat counter.
- `KEYPAD_AUTOREPEAT_EN` undefined:
  - No repeat logic is built.
  - `key_strobe` pulses exactly once per press; `REPEAT_TICKS` is ignored.

## Test plan
All scenarios use `CLK_DIV`=4 and `DEBOUNCE_TICKS`=3.
- Reset → `keypad_col_out` = 4'b1110 and all outputs 0. Idle rows cycle the column drive 1110→1101→1011→0111→1110, with each pattern held 4 cycles.
- Row 2 pulled low while column 1 is driven, held for 40 cycles → `row_out` = 4'b0100, `col_out` = 4'b0010, `key_pressed` = 1, a single `key_strobe` pulse. Timing matches the press latency above.
- Release of that key → `key_pressed` falls after 3 released ticks and `row_out`/`col_out` clear to 0. Scanning resumes at column 2.
- Bounce: row low for 1 tick, high for 1 tick, then low and held → no strobe during the bounce. Exactly one press is reported once 3 stable ticks follow.
- Rows 0 and 1 both low on one column → never confirmed, no strobe, scanning continues. A release glitch of 1 tick during HELD → `key_pressed` stays 1.
- With `KEYPAD_AUTOREPEAT_EN` and `REPEAT_TICKS`=5, key held for 20 ticks after confirmation → 4 additional strobes spaced 20 cycles apart. Reset asserted mid-hold → all outputs 0 on the next edge.
